// File: rtl/riscv_dmem_responder_if.sv
// CPU data-memory request/response bus: one request channel, one response channel,
// each with its own valid/ready handshake.
interface riscv_dmem_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wr_en;
  logic [31:0] i_req_addr;
  logic [3:0]  i_req_byte_sel;
  logic [31:0] i_req_wr_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rd_data;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_req_wr_en, i_req_addr, i_req_byte_sel, i_req_wr_data, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rd_data, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_wr_en, i_req_addr, i_req_byte_sel, i_req_wr_data, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rd_data, o_rsp_err
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Single-outstanding data memory; response valid WAIT_CYCLES+1 cycles after acceptance.
// Request ready only in IDLE; the response is held until the CPU takes it.
module riscv_dmem_responder #(
  parameter int DMEM_ADDR_BIT = 10,
  parameter int WAIT_CYCLES   = 2
) (
  input logic                   i_clk,
  input logic                   i_rstn,
  riscv_dmem_responder_if.slave bus
);
  localparam int         DEPTH    = 2 ** (DMEM_ADDR_BIT - 2);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef struct packed {
    logic        wr_en;
    logic [31:0] addr;
    logic [3:0]  byte_sel;
    logic [31:0] wr_data;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state, state_nxt;
  logic [3:0]               cnt;
  req_t                     req_in, req_q, acc;
  logic                     enter_resp;
  logic                     oor;
  logic [DMEM_ADDR_BIT-3:0] idx;
  logic [31:0]              rd_data_q;
  logic                     err_q;
  logic [31:0]              mem [DEPTH];
  logic                     unused_addr_lsb;

  assign req_in = {bus.i_req_wr_en, bus.i_req_addr, bus.i_req_byte_sel, bus.i_req_wr_data};
  // With zero wait cycles the access happens on the accept edge, before req_q is loaded.
  assign acc             = (state == IDLE) ? req_in : req_q;
  assign oor             = |acc.addr[31:DMEM_ADDR_BIT];
  assign idx             = acc.addr[DMEM_ADDR_BIT-1:2];
  assign unused_addr_lsb = ^acc.addr[1:0];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt       <= 4'd0;
      req_q     <= '0;
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && bus.i_req_valid) begin
        req_q <= req_in;
        cnt   <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        rd_data_q <= (!acc.wr_en && !oor) ? mem[idx] : 32'd0;
        err_q     <= oor;
      end else if (state == RESP && bus.i_rsp_ready) begin
        rd_data_q <= 32'd0;
        err_q     <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; the i_rstn term blocks writes while reset is held.
  always_ff @(posedge i_clk) begin
    if (i_rstn && enter_resp && acc.wr_en && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc.byte_sel[b]) mem[idx][8*b +: 8] <= acc.wr_data[8*b +: 8];
      end
    end
  end

  assign bus.o_req_ready   = (state == IDLE);
  assign bus.o_rsp_valid   = (state == RESP);
  assign bus.o_rsp_rd_data = rd_data_q;
  assign bus.o_rsp_err     = err_q;
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench: a 2-wait-cycle responder and a 0-wait-cycle responder share one stimulus bus.
module tb_riscv_dmem_responder;
  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        req_valid, wr_en, rsp_ready;
  logic [31:0] addr, wd;
  logic [3:0]  bs;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rd_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  riscv_dmem_responder_if bif ();
  riscv_dmem_responder_if bif0 ();

  assign bif.i_req_valid     = req_valid & ~sel;
  assign bif.i_req_wr_en     = wr_en;
  assign bif.i_req_addr      = addr;
  assign bif.i_req_byte_sel  = bs;
  assign bif.i_req_wr_data   = wd;
  assign bif.i_rsp_ready     = rsp_ready & ~sel;
  assign bif0.i_req_valid    = req_valid & sel;
  assign bif0.i_req_wr_en    = wr_en;
  assign bif0.i_req_addr     = addr;
  assign bif0.i_req_byte_sel = bs;
  assign bif0.i_req_wr_data  = wd;
  assign bif0.i_rsp_ready    = rsp_ready & sel;

  assign req_ready   = sel ? bif0.o_req_ready   : bif.o_req_ready;
  assign rsp_valid   = sel ? bif0.o_rsp_valid   : bif.o_rsp_valid;
  assign rsp_rd_data = sel ? bif0.o_rsp_rd_data : bif.o_rsp_rd_data;
  assign rsp_err     = sel ? bif0.o_rsp_err     : bif.o_rsp_err;

  riscv_dmem_responder #(.DMEM_ADDR_BIT(10), .WAIT_CYCLES(2)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bif)
  );

  riscv_dmem_responder #(.DMEM_ADDR_BIT(10), .WAIT_CYCLES(0)) dut0 (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bif0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat);
    wr_en = w; addr = a; bs = b; wd = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rd_data;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(w, a, b, d, rd, er, lat);
    chk({tag, ".lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
    chk({tag, ".rd"}, rd, exp_rd);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, ".idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    chk({tag, ".rd_clr"}, rsp_rd_data, 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".seen"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; sel = 1'b0; req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b0;
    addr = 32'd0; wd = 32'd0; bs = 4'd0;
    repeat (2) @(posedge clk); #1;
    chk("rst.vld", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rd", rsp_rd_data, 32'd0);
    chk("rst.err", {31'd0, rsp_err}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst.rdy", {31'd0, req_ready}, 32'd1);

    xact("wr_full", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0);
    xact("rd_full", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEADBEEF, 1'b0);
    xact("wr_b0", 1'b1, 32'h10, 4'b0001, 32'h000000AA, 32'd0, 1'b0);
    xact("rd_b0", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEADBEAA, 1'b0);
    xact("wr_nobe", 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'd0, 1'b0);
    xact("rd_nobe", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEADBEAA, 1'b0);
    xact("wr_unal", 1'b1, 32'h13, 4'b0010, 32'h00005500, 32'd0, 1'b0);
    xact("rd_unal", 1'b0, 32'h12, 4'hF, 32'd0, 32'hDEAD55AA, 1'b0);
    xact("wr_w0", 1'b1, 32'h0, 4'hF, 32'h11223344, 32'd0, 1'b0);
    xact("wr_top", 1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0);
    xact("rd_top", 1'b0, 32'h3FC, 4'hF, 32'd0, 32'hCAFEF00D, 1'b0);
    xact("wr_oor", 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1);
    xact("rd_oor", 1'b0, 32'h400, 4'hF, 32'd0, 32'd0, 1'b1);
    xact("rd_hi", 1'b0, 32'h8000_0000, 4'hF, 32'd0, 32'd0, 1'b1);
    xact("rd_w0", 1'b0, 32'h0, 4'hF, 32'd0, 32'h11223344, 1'b0);

    // Response stall with an intruding write that must be ignored.
    wr_en = 1'b0; addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp("stall");
    wr_en = 1'b1; addr = 32'h10; wd = 32'h0; bs = 4'hF; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall.vld", {31'd0, rsp_valid}, 32'd1);
      chk("stall.rd", rsp_rd_data, 32'hDEAD55AA);
      chk("stall.rdy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("b2b.idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    xact("rd_stall", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEAD55AA, 1'b0);

    // Reset while a read response is pending.
    wr_en = 1'b0; addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp("rstresp");
    chk("rstresp.pre", rsp_rd_data, 32'hDEAD55AA);
    rstn = 1'b0;
    #1;
    chk("rstresp.vld", {31'd0, rsp_valid}, 32'd0);
    chk("rstresp.rd", rsp_rd_data, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rstresp.rdy", {31'd0, req_ready}, 32'd1);

    // Reset during the wait phase of a write.
    xact("wr_20", 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 32'd0, 1'b0);
    wr_en = 1'b1; addr = 32'h20; wd = 32'h12345678; bs = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstwait.busy", {31'd0, req_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("rstwait.rdy", {31'd0, req_ready}, 32'd1);
    chk("rstwait.vld", {31'd0, rsp_valid}, 32'd0);
    chk("rstwait.err", {31'd0, rsp_err}, 32'd0);
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    xact("rd_20", 1'b0, 32'h20, 4'hF, 32'd0, 32'h0BADF00D, 1'b0);
    xact("rd_keep", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEAD55AA, 1'b0);

    // Zero-wait responder.
    sel = 1'b1;
    @(posedge clk); #1;
    xact("z.wr", 1'b1, 32'h8, 4'hF, 32'h55AA55AA, 32'd0, 1'b0);
    xact("z.rd", 1'b0, 32'h8, 4'hF, 32'd0, 32'h55AA55AA, 1'b0);
    xact("z.oor", 1'b0, 32'h400, 4'hF, 32'd0, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
